// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// serial_adder_ctrl: bit-serial add/subtract engine.
// One full-adder slice is reused for WIDTH cycles, LSB first, with a carry
// flip-flop between bits. Results shift into sum from the MSB side.
//
// Handshake: start is sampled only in IDLE; once taken, busy is high for
// exactly WIDTH cycles, then done is high for exactly one cycle and the
// engine returns to IDLE. start seen in RUN or DONE is dropped. busy and done
// are flops (never both high), so the state is fully visible as
// {busy, done}: 00 = IDLE, 10 = RUN, 01 = DONE.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The single full-adder slice working on the current LSBs.
    logic s_bit;
    logic c_next;
    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    // Next-state, datapath update and registered status decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1; the +1 rides in on the carry.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                sum_d  = {s_bit, sum_q[WIDTH-1:1]};
                c_d    = c_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // c_q is the carry into the MSB on this edge.
                    cout_d  = c_next;
                    ovf_d   = c_q ^ c_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bench for serial_adder_ctrl (WIDTH=8).
// The driver issues operations and pushes the expected {sum, cout, ovf}
// into exp_q; a monitor on the falling edge pops and compares whenever done
// is high, and also checks busy/done every cycle against a small timing
// model and checks that results hold through IDLE.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    logic [W+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub_i),
        .a    (a_i),
        .b    (b_i),
        .cin  (cin_i),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- timing model ----------------
    // 0 = idle, 1 = run, 2 = done
    int   m_st = 0;
    int   m_cnt = 0;
    logic m_reset_evt = 1'b0;
    logic mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st        = 0;
            m_cnt       = 0;
            m_reset_evt = 1'b1;
            mon_en      = 1'b1;
        end else begin
            m_reset_evt = 1'b0;
            case (m_st)
                0: if (start) begin m_st = 1; m_cnt = 0; end
                1: if (m_cnt == W - 1) m_st = 2; else m_cnt = m_cnt + 1;
                default: m_st = 0;
            endcase
        end
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s, input logic ci);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         c0;
        logic         ov;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
        ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {full[W-1:0], full[W], ov};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W+1:0] held = '0;
    logic [W+1:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (m_reset_evt) held = '0;
                chk("busy", {31'd0, busy}, {31'd0, m_st == 1});
                chk("done", {31'd0, done}, {31'd0, m_st == 2});
                chk("busy_and_done", {31'd0, busy & done}, 32'd0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e    = exp_q.pop_front();
                        held = e;
                        chk("sum", {24'd0, sum}, {24'd0, e[W+1:2]});
                        chk("cout", {31'd0, cout}, {31'd0, e[1]});
                        chk("ovf", {31'd0, ovf}, {31'd0, e[0]});
                    end
                end else if (m_st == 0) begin
                    chk("hold_sum", {24'd0, sum}, {24'd0, held[W+1:2]});
                    chk("hold_flags", {30'd0, cout, ovf}, {30'd0, held[1:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (m_st != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_model_done();
        int n;
        n = 0;
        while (m_st != 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic ci, input logic [W+1:0] expv);
        wait_idle();
        a_i   = x;
        b_i   = y;
        sub_i = s;
        cin_i = ci;
        start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        // Operands are free to change once sampled.
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        sub_i = 1'($urandom);
        cin_i = 1'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub_i = 1'b0;
        a_i   = '0;
        b_i   = '0;
        cin_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed vectors: expected {sum, cout, ovf} computed by hand.
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, {8'h96, 1'b0, 1'b1});
        do_op(8'hFF, 8'h00, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
        do_op(8'h7F, 8'h00, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1});
        do_op(8'h10, 8'h20, 1'b1, 1'b1, {8'hF0, 1'b0, 1'b0});
        do_op(8'h80, 8'h01, 1'b1, 1'b0, {8'h7F, 1'b1, 1'b1});
        do_op(8'h05, 8'h05, 1'b1, 1'b0, {8'h00, 1'b1, 1'b0});
        do_op(8'h00, 8'h01, 1'b1, 1'b0, {8'hFF, 1'b0, 1'b0});
        do_op(8'h80, 8'h80, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1});
        // Idle gap: results must hold.
        repeat (5) @(negedge clk);

        // start held high: back-to-back ops, operands changed mid-RUN.
        wait_idle();
        a_i   = 8'h01;
        b_i   = 8'h01;
        sub_i = 1'b0;
        cin_i = 1'b0;
        start = 1'b1;
        exp_q.push_back({8'h02, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_i = 8'h33;
            b_i = 8'h44;
            wait_model_done();
            a_i = 8'h01;
            b_i = 8'h01;
            @(negedge clk);
            exp_q.push_back({8'h02, 1'b0, 1'b0});
        end
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of an operation: no done, everything cleared.
        wait_idle();
        a_i   = 8'hAA;
        b_i   = 8'h55;
        sub_i = 1'b0;
        cin_i = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_op(8'hAA, 8'h55, 1'b0, 1'b0, {8'hFF, 1'b0, 1'b0});

        // Random operations against the reference arithmetic.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         s;
            logic         ci;
            x  = W'($urandom_range(0, 255));
            y  = W'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            do_op(x, y, s, ci, ref_calc(x, y, s, ci));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
